// File: rtl/regwr_pkg.sv
// Shared types and constants for the register-file write controller.
package regwr_pkg;

  localparam int unsigned REGWR_DATA_W = 32;
  localparam int unsigned REGWR_ADDR_W = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [REGWR_ADDR_W-1:0] rd;
    logic [REGWR_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/load_ext.sv
// Load alignment: selects the addressed byte/half from a memory word and sign/zero-extends it.
module load_ext
  import regwr_pkg::*;
#(
  parameter int unsigned DATA_W = REGWR_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[{offset, 3'b000} +: 8];
    // offset[0] is ignored for halves: the pair is chosen by offset[1] only
    half_sel = data[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: result = {{(DATA_W-8){sgn & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{(DATA_W-16){sgn & half_sel[15]}}, half_sel};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write controller: merges MEM and ALU results into an in-order FIFO, one write/cycle.
// Optional forwarding lookup of pending writes is built when REGWR_FWD_EN is defined.
module regfile_write_ctrl
  import regwr_pkg::*;
#(
  parameter int unsigned DATA_W = REGWR_DATA_W,
  parameter int unsigned ADDR_W = REGWR_ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [1:0]        mem_offset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              we,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] fwd_rs,
  input  logic [ADDR_W-1:0] fwd_rt,
  output logic              fwd_rs_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rt_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wr_entry_t          fifo_q [DEPTH];
  wr_entry_t          head;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   alu_slot;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   free;
  logic [DATA_W-1:0]  mem_ext;
  logic               mem_enq, alu_enq, pop;
  logic [1:0]         enq_n;

  load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .data   (mem_data),
    .size   (mem_size),
    .sgn    (mem_signed),
    .offset (mem_offset),
    .result (mem_ext)
  );

  always_comb begin
    free      = CNT_W'(DEPTH) - count_q;
    mem_ready = (free != '0);
    // ALU may only take the last slot when MEM is not competing for it
    alu_ready = (free >= CNT_W'(2)) | ((free != '0) & ~mem_valid);
    // $0 results are handshaken but dropped
    mem_enq   = mem_valid & mem_ready & (mem_rd != '0);
    alu_enq   = alu_valid & alu_ready & (alu_rd != '0);
    pop       = (count_q != '0);
    enq_n     = {1'b0, mem_enq} + {1'b0, alu_enq};
    alu_slot  = wr_ptr_q + PTR_W'(mem_enq);
    count_d   = count_q + CNT_W'(enq_n) - CNT_W'(pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(enq_n);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; occupancy is tracked solely by count_q
  always_ff @(posedge clk) begin
    if (mem_enq) fifo_q[wr_ptr_q] <= '{rd: mem_rd, data: mem_ext};
    if (alu_enq) fifo_q[alu_slot] <= '{rd: alu_rd, data: alu_data};
  end

  always_comb begin
    head   = fifo_q[rd_ptr_q];
    we     = pop;
    rd     = pop ? head.rd : '0;
    dataIn = pop ? head.data : '0;
  end

`ifdef REGWR_FWD_EN
  // Walk oldest to youngest so the last match wins
  always_comb begin
    fwd_rs_hit  = 1'b0;
    fwd_rs_data = '0;
    fwd_rt_hit  = 1'b0;
    fwd_rt_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        if ((fwd_rs != '0) && (fifo_q[rd_ptr_q + PTR_W'(i)].rd == fwd_rs)) begin
          fwd_rs_hit  = 1'b1;
          fwd_rs_data = fifo_q[rd_ptr_q + PTR_W'(i)].data;
        end
        if ((fwd_rt != '0) && (fifo_q[rd_ptr_q + PTR_W'(i)].rd == fwd_rt)) begin
          fwd_rt_hit  = 1'b1;
          fwd_rt_data = fifo_q[rd_ptr_q + PTR_W'(i)].data;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd  = ^{fwd_rs, fwd_rt};
  assign fwd_rs_hit  = 1'b0;
  assign fwd_rs_data = '0;
  assign fwd_rt_hit  = 1'b0;
  assign fwd_rt_data = '0;
`endif

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: reset, latency, load extension, arbitration, $0, forwarding.
module tb_regfile_write_ctrl;

`ifdef REGWR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ready, mem_signed;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [1:0]  mem_size, mem_offset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] dataIn;
  logic [4:0]  fwd_rs, fwd_rt;
  logic        fwd_rs_hit, fwd_rt_hit;
  logic [31:0] fwd_rs_data, fwd_rt_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_ctrl #(
    .DATA_W (32),
    .ADDR_W (5),
    .DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_size    (mem_size),
    .mem_signed  (mem_signed),
    .mem_offset  (mem_offset),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .we          (we),
    .rd          (rd),
    .dataIn      (dataIn),
    .fwd_rs      (fwd_rs),
    .fwd_rt      (fwd_rt),
    .fwd_rs_hit  (fwd_rs_hit),
    .fwd_rs_data (fwd_rs_data),
    .fwd_rt_hit  (fwd_rt_hit),
    .fwd_rt_data (fwd_rt_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
  endtask

  task automatic check_wr(input string tag, input logic ewe, input logic [4:0] erd,
                          input logic [31:0] edata);
    check({tag, ".we"}, 32'(we), 32'(ewe));
    check({tag, ".rd"}, 32'(rd), 32'(erd));
    check({tag, ".data"}, dataIn, edata);
  endtask

  task automatic check_rdy(input string tag, input logic emr, input logic ear);
    check({tag, ".mem_ready"}, 32'(mem_ready), 32'(emr));
    check({tag, ".alu_ready"}, 32'(alu_ready), 32'(ear));
  endtask

  initial begin
    rst        = 1'b1;
    mem_size   = 2'b10;
    mem_signed = 1'b0;
    mem_offset = 2'b00;
    fwd_rs     = 5'd0;
    fwd_rt     = 5'd0;
    drive(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222);

    // Reset held for two edges with both sources valid
    next();
    @(negedge clk);
    check_wr("rst1", 1'b0, 5'd0, 32'h0);
    check_rdy("rst1", 1'b1, 1'b1);
    check("rst1.fwd_rs_hit", 32'(fwd_rs_hit), 32'd0);
    check("rst1.fwd_rs_data", fwd_rs_data, 32'h0);
    next();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check_wr("rst2", 1'b0, 5'd0, 32'h0);
    next();
    @(negedge clk);
    check_wr("post_rst", 1'b0, 5'd0, 32'h0);
    check_rdy("post_rst", 1'b1, 1'b1);

    // Single ALU write: visible for exactly one cycle
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h1002_aaff);
    @(negedge clk);
    check("alu1.alu_ready", 32'(alu_ready), 32'd1);
    check("alu1.pre_we", 32'(we), 32'd0);
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check_wr("alu1.write", 1'b1, 5'd3, 32'h1002_aaff);
    next();
    @(negedge clk);
    check_wr("alu1.after", 1'b0, 5'd0, 32'h0);

    // Load extension, back-to-back loads from the same word
    next();
    drive(1'b1, 5'd4, 32'h80F1_7F01, 1'b0, 5'd0, 32'h0);
    mem_size = 2'b00; mem_signed = 1'b1; mem_offset = 2'd3;
    @(negedge clk);
    check("ld.pre_we", 32'(we), 32'd0);
    next();
    mem_size = 2'b00; mem_signed = 1'b0; mem_offset = 2'd1;
    @(negedge clk);
    check_wr("ld.sb3", 1'b1, 5'd4, 32'hFFFF_FF80);
    next();
    mem_size = 2'b01; mem_signed = 1'b1; mem_offset = 2'd2;
    @(negedge clk);
    check_wr("ld.ub1", 1'b1, 5'd4, 32'h0000_007F);
    next();
    mem_size = 2'b01; mem_signed = 1'b0; mem_offset = 2'd3;
    @(negedge clk);
    check_wr("ld.sh2", 1'b1, 5'd4, 32'hFFFF_80F1);
    next();
    mem_size = 2'b10; mem_signed = 1'b1; mem_offset = 2'd0;
    @(negedge clk);
    check_wr("ld.uh3", 1'b1, 5'd4, 32'h0000_80F1);
    next();
    mem_valid = 1'b0;
    @(negedge clk);
    check_wr("ld.word", 1'b1, 5'd4, 32'h80F1_7F01);
    next();
    @(negedge clk);
    check_wr("ld.after", 1'b0, 5'd0, 32'h0);

    // Dual accept then backpressure: ALU starves while MEM keeps the last slot
    next();
    mem_size = 2'b10; mem_signed = 1'b0; mem_offset = 2'd0;
    drive(1'b1, 5'd8, 32'h1000_0000, 1'b1, 5'd16, 32'h2000_0000);
    @(negedge clk);
    check_rdy("dual.c0", 1'b1, 1'b1);
    check("dual.c0.we", 32'(we), 32'd0);
    next();
    drive(1'b1, 5'd9, 32'h1000_0001, 1'b1, 5'd17, 32'h2000_0001);
    @(negedge clk);
    check_rdy("dual.c1", 1'b1, 1'b1);
    check_wr("dual.c1", 1'b1, 5'd8, 32'h1000_0000);
    next();
    drive(1'b1, 5'd10, 32'h1000_0002, 1'b1, 5'd18, 32'h2000_0002);
    @(negedge clk);
    check_rdy("dual.c2", 1'b1, 1'b0);
    check_wr("dual.c2", 1'b1, 5'd16, 32'h2000_0000);
    next();
    drive(1'b1, 5'd11, 32'h1000_0003, 1'b1, 5'd18, 32'h2000_0002);
    @(negedge clk);
    check_rdy("dual.c3", 1'b1, 1'b0);
    check_wr("dual.c3", 1'b1, 5'd9, 32'h1000_0001);
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd18, 32'h2000_0002);
    @(negedge clk);
    check_rdy("dual.c4", 1'b1, 1'b1);
    check_wr("dual.c4", 1'b1, 5'd17, 32'h2000_0001);
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check_wr("dual.c5", 1'b1, 5'd10, 32'h1000_0002);
    next();
    @(negedge clk);
    check_wr("dual.c6", 1'b1, 5'd11, 32'h1000_0003);
    next();
    @(negedge clk);
    check_wr("dual.c7", 1'b1, 5'd18, 32'h2000_0002);
    next();
    @(negedge clk);
    check_wr("dual.c8", 1'b0, 5'd0, 32'h0);

    // $0 discard alongside a real ALU write
    next();
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd5, 32'h0000_0055);
    @(negedge clk);
    check_rdy("zero.acc", 1'b1, 1'b1);
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check_wr("zero.w5", 1'b1, 5'd5, 32'h0000_0055);
    next();
    @(negedge clk);
    check_wr("zero.after", 1'b0, 5'd0, 32'h0);

    // Forwarding: two pending writes to r7, youngest wins
    next();
    drive(1'b1, 5'd7, 32'h0000_0011, 1'b1, 5'd7, 32'h0000_0022);
    fwd_rs = 5'd7;
    fwd_rt = 5'd9;
    @(negedge clk);
    check("fwd.same_cycle.hit", 32'(fwd_rs_hit), 32'd0);
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("fwd.rs7.hit", 32'(fwd_rs_hit), 32'(FWD));
    check("fwd.rs7.data", fwd_rs_data, FWD ? 32'h0000_0022 : 32'h0);
    check("fwd.rt9.hit", 32'(fwd_rt_hit), 32'd0);
    check("fwd.rt9.data", fwd_rt_data, 32'h0);
    check_wr("fwd.w0", 1'b1, 5'd7, 32'h0000_0011);
    next();
    fwd_rs = 5'd0;
    fwd_rt = 5'd7;
    @(negedge clk);
    check("fwd.rs0.hit", 32'(fwd_rs_hit), 32'd0);
    check("fwd.rt7.hit", 32'(fwd_rt_hit), 32'(FWD));
    check("fwd.rt7.data", fwd_rt_data, FWD ? 32'h0000_0022 : 32'h0);
    check_wr("fwd.w1", 1'b1, 5'd7, 32'h0000_0022);
    next();
    @(negedge clk);
    check("fwd.empty.hit", 32'(fwd_rt_hit), 32'd0);
    check_wr("fwd.after", 1'b0, 5'd0, 32'h0);

    // Reset mid-operation discards pending entries
    next();
    drive(1'b1, 5'd10, 32'hAAAA_0000, 1'b1, 5'd11, 32'hBBBB_0000);
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_wr("midrst.pending", 1'b1, 5'd10, 32'hAAAA_0000);
    next();
    rst = 1'b0;
    @(negedge clk);
    check_wr("midrst.cleared", 1'b0, 5'd0, 32'h0);
    next();
    @(negedge clk);
    check_wr("midrst.idle", 1'b0, 5'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
